// File: rtl/fir_tap_delay_line.sv
// FIR tap delay line: strobed shift register exposing all taps.
// Optional symmetric pre-adder enabled by macro SYM_PREADD_EN.
module fir_tap_delay_line #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 40,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   iClk12M,
  input  logic                   iRst,
  input  logic                   iEnSample,
  input  logic                   iClear,
  input  logic [WIDTH-1:0]       iFirIn,
  output logic [DEPTH*WIDTH-1:0] oTapBus,
  output logic                   oTapValid,
  output logic                   oFull,
  output logic [CNT_W-1:0]       oFillCnt
`ifdef SYM_PREADD_EN
  ,
  output logic [(DEPTH/2)*(WIDTH+1)-1:0] oPreAdd,
  output logic                           oPreValid
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic             shift;
  logic [CNT_W-1:0] cnt_nxt;

  assign shift = iEnSample & ~iClear;

  // Next fill count: clear wins, saturate at DEPTH.
  always_comb begin
    cnt_nxt = oFillCnt;
    if (iClear)
      cnt_nxt = '0;
    else if (iEnSample && (oFillCnt != DEPTH_C))
      cnt_nxt = oFillCnt + 1'b1;
  end

  // Tap chain; tap 0 sits in the low slice.
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst)
      oTapBus <= '0;
    else if (iClear)
      oTapBus <= '0;
    else if (iEnSample)
      oTapBus <= {oTapBus[(DEPTH-1)*WIDTH-1:0], iFirIn};
  end

  // Status flags and fill count.
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      oTapValid <= 1'b0;
      oFull     <= 1'b0;
      oFillCnt  <= '0;
    end else begin
      oTapValid <= shift;
      oFull     <= (cnt_nxt == DEPTH_C);
      oFillCnt  <= cnt_nxt;
    end
  end

`ifdef SYM_PREADD_EN
  localparam int HALF = DEPTH / 2;
  localparam int PW   = WIDTH + 1;

  if ((DEPTH % 2) != 0) begin : g_odd
    $error("fir_tap_delay_line: DEPTH must be even");
  end

  logic [HALF*PW-1:0] pre_nxt;

  // Sign-extended sums of mirrored tap pairs.
  always_comb begin
    pre_nxt = '0;
    for (int j = 0; j < HALF; j++) begin
      pre_nxt[j*PW +: PW] =
        {oTapBus[j*WIDTH+WIDTH-1], oTapBus[j*WIDTH +: WIDTH]} +
        {oTapBus[(DEPTH-1-j)*WIDTH+WIDTH-1],
         oTapBus[(DEPTH-1-j)*WIDTH +: WIDTH]};
    end
  end

  // Pre-add register follows the tap update by one cycle.
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      oPreAdd   <= '0;
      oPreValid <= 1'b0;
    end else if (iClear) begin
      oPreAdd   <= '0;
      oPreValid <= 1'b0;
    end else begin
      oPreValid <= oTapValid;
      if (oTapValid)
        oPreAdd <= pre_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fir_tap_delay_line.sv
// Scoreboard bench for fir_tap_delay_line.
// Expected tap state is modelled in the bench and queued per strobe.
module tb_fir_tap_delay_line;

  localparam int W  = 3;
  localparam int D  = 40;
  localparam int CW = $clog2(D + 1);
  localparam int BW = D * W;

  logic          iClk12M = 1'b0;
  logic          iRst = 1'b1;
  logic          iEnSample = 1'b0;
  logic          iClear = 1'b0;
  logic [W-1:0]  iFirIn = '0;
  logic [BW-1:0] oTapBus;
  logic          oTapValid;
  logic          oFull;
  logic [CW-1:0] oFillCnt;
`ifdef SYM_PREADD_EN
  logic [(D/2)*(W+1)-1:0] oPreAdd;
  logic                   oPreValid;
`endif

  fir_tap_delay_line #(.WIDTH(W), .DEPTH(D)) dut (
    .iClk12M  (iClk12M),
    .iRst     (iRst),
    .iEnSample(iEnSample),
    .iClear   (iClear),
    .iFirIn   (iFirIn),
    .oTapBus  (oTapBus),
    .oTapValid(oTapValid),
    .oFull    (oFull),
`ifdef SYM_PREADD_EN
    .oPreAdd  (oPreAdd),
    .oPreValid(oPreValid),
`endif
    .oFillCnt (oFillCnt)
  );

  always #5 iClk12M = ~iClk12M;

  typedef struct {
    logic [BW-1:0] bus;
    int            cnt;
    logic          full;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e;
  logic [BW-1:0] mbus;
  int            mcnt;
  int            total = 0;
  int            bad = 0;

  task automatic mdl_clear();
    mbus = '0;
    mcnt = 0;
  endtask

  // Drive one strobe at negedge, queue expectation, return 1ns after edge.
  task automatic drive_strobe(input logic [W-1:0] v);
    exp_t x;
    @(negedge iClk12M);
    iEnSample = 1'b1;
    iFirIn    = v;
    mbus = {mbus[BW-W-1:0], v};
    if (mcnt < D) mcnt++;
    x.bus  = mbus;
    x.cnt  = mcnt;
    x.full = (mcnt == D);
    sbq.push_back(x);
    @(posedge iClk12M);
    #1;
  endtask

  task automatic idle(input int n);
    iEnSample = 1'b0;
    repeat (n) @(posedge iClk12M);
    #1;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    #12;
    total++;
    if (oTapBus !== '0) begin
      bad++; $display("FAIL rst_bus: got %h want 0", oTapBus);
    end
    total++;
    if ({oTapValid, oFull} !== 2'b00) begin
      bad++; $display("FAIL rst_flags: got %b want 00", {oTapValid, oFull});
    end
    total++;
    if (oFillCnt !== '0) begin
      bad++; $display("FAIL rst_cnt: got %0d want 0", oFillCnt);
    end
    @(negedge iClk12M);
    iRst = 1'b0;
    mdl_clear();
  endtask

  task automatic test_fill();
    for (int n = 1; n <= D + 1; n++) begin
      drive_strobe(W'((n - 1) % 8));
      total++;
      if (oTapValid !== 1'b1) begin
        bad++; $display("FAIL fill_valid n=%0d: got %b want 1", n, oTapValid);
      end
      e = sbq.pop_front();
      total++;
      if (oTapBus !== e.bus || oFillCnt !== CW'(e.cnt) || oFull !== e.full) begin
        bad++;
        $display("FAIL fill_sb n=%0d: got %h/%0d/%b want %h/%0d/%b",
                 n, oTapBus, oFillCnt, oFull, e.bus, e.cnt, e.full);
      end
      total++;
      if (oTapBus[W-1:0] !== W'((n - 1) % 8)) begin
        bad++; $display("FAIL fill_tap0 n=%0d: got %0d want %0d", n, oTapBus[W-1:0], (n - 1) % 8);
      end
      total++;
      if (oFillCnt !== CW'((n > D) ? D : n) || oFull !== (n >= D)) begin
        bad++; $display("FAIL fill_cnt n=%0d: got %0d/%b", n, oFillCnt, oFull);
      end
      idle(1);
      total++;
      if (oTapValid !== 1'b0) begin
        bad++; $display("FAIL fill_pulse n=%0d: got %b want 0", n, oTapValid);
      end
      idle(18);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 100; i++) begin
      iFirIn = W'(i);
      @(posedge iClk12M);
      #1;
      total++;
      if (oTapBus !== mbus || oTapValid !== 1'b0) begin
        bad++; $display("FAIL hold i=%0d: got %h/%b want %h/0", i, oTapBus, oTapValid, mbus);
      end
    end
  endtask

  task automatic test_impulse();
    logic [BW-1:0] want;
    @(negedge iClk12M);
    iClear = 1'b1;
    @(posedge iClk12M);
    #1;
    iClear = 1'b0;
    mdl_clear();
    total++;
    if (oTapBus !== '0 || oFillCnt !== '0) begin
      bad++; $display("FAIL imp_clr: got %h/%0d want 0/0", oTapBus, oFillCnt);
    end
    for (int n = 1; n <= D + 1; n++) begin
      drive_strobe((n == 1) ? W'(1) : W'(0));
      want = '0;
      if (n <= D) want[(n - 1) * W] = 1'b1;
      e = sbq.pop_front();
      total++;
      if (oTapBus !== want || oTapBus !== e.bus || oTapValid !== 1'b1) begin
        bad++; $display("FAIL impulse n=%0d: got %h/%b want %h/1", n, oTapBus, oTapValid, want);
      end
      total++;
      if (oFillCnt !== CW'(e.cnt) || oFull !== e.full) begin
        bad++; $display("FAIL imp_cnt n=%0d: got %0d/%b want %0d/%b", n, oFillCnt, oFull, e.cnt, e.full);
      end
    end
    idle(1);
    total++;
    if (oTapValid !== 1'b0) begin
      bad++; $display("FAIL imp_end_valid: got %b want 0", oTapValid);
    end
  endtask

  task automatic test_clear_collide();
    total++;
    if (oFull !== 1'b1) begin
      bad++; $display("FAIL pre_clr_full: got %b want 1", oFull);
    end
    @(negedge iClk12M);
    iClear    = 1'b1;
    iEnSample = 1'b1;
    iFirIn    = 3'b111;
    @(posedge iClk12M);
    #1;
    iClear    = 1'b0;
    iEnSample = 1'b0;
    mdl_clear();
    total++;
    if (oTapBus !== '0) begin
      bad++; $display("FAIL clr_bus: got %h want 0", oTapBus);
    end
    total++;
    if (oFillCnt !== '0 || oFull !== 1'b0 || oTapValid !== 1'b0) begin
      bad++; $display("FAIL clr_flags: got %0d/%b/%b want 0/0/0", oFillCnt, oFull, oTapValid);
    end
  endtask

  task automatic test_async_reset();
    for (int n = 1; n <= 17; n++) begin
      drive_strobe(W'($urandom_range(0, 7)));
      e = sbq.pop_front();
      total++;
      if (oTapBus !== e.bus || oFillCnt !== CW'(e.cnt) || oTapValid !== 1'b1) begin
        bad++; $display("FAIL ar_sb n=%0d: got %h/%0d want %h/%0d", n, oTapBus, oFillCnt, e.bus, e.cnt);
      end
    end
    iEnSample = 1'b0;
    #2;
    iRst = 1'b1;
    #1;
    total++;
    if (oTapBus !== '0 || oFillCnt !== '0 || oFull !== 1'b0 || oTapValid !== 1'b0) begin
      bad++; $display("FAIL async_rst: got %h/%0d/%b/%b want 0", oTapBus, oFillCnt, oFull, oTapValid);
    end
    @(negedge iClk12M);
    iRst = 1'b0;
    mdl_clear();
    drive_strobe(3'd5);
    e = sbq.pop_front();
    total++;
    if (oFillCnt !== CW'(1) || oTapBus !== e.bus || oTapValid !== 1'b1) begin
      bad++; $display("FAIL ar_first: got %0d/%h want 1/%h", oFillCnt, oTapBus, e.bus);
    end
    idle(2);
  endtask

`ifdef SYM_PREADD_EN
  task automatic test_preadd();
    logic [W:0] a, b, s, c;
    @(negedge iClk12M);
    iClear = 1'b1;
    @(posedge iClk12M);
    #1;
    iClear = 1'b0;
    mdl_clear();
    for (int n = 0; n < D; n++) begin
      drive_strobe(3'b011);
      e = sbq.pop_front();
    end
    idle(5);
    drive_strobe(3'b100);
    e = sbq.pop_front();
    total++;
    if (oTapValid !== 1'b1 || oPreValid !== 1'b0 || oTapBus !== e.bus) begin
      bad++; $display("FAIL pa_stage1: got %b/%b want 1/0", oTapValid, oPreValid);
    end
    idle(1);
    total++;
    if (oPreValid !== 1'b1) begin
      bad++; $display("FAIL pa_valid: got %b want 1", oPreValid);
    end
    for (int j = 0; j < D / 2; j++) begin
      a = {mbus[j*W+W-1], mbus[j*W +: W]};
      b = {mbus[(D-1-j)*W+W-1], mbus[(D-1-j)*W +: W]};
      s = a + b;
      c = (j == 0) ? 4'b1111 : 4'b0110;
      total++;
      if (oPreAdd[j*(W+1) +: W+1] !== s || s !== c) begin
        bad++; $display("FAIL pa_sum j=%0d: got %b want %b", j, oPreAdd[j*(W+1) +: W+1], c);
      end
    end
    idle(1);
    total++;
    if (oPreValid !== 1'b0) begin
      bad++; $display("FAIL pa_pulse: got %b want 0", oPreValid);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    mdl_clear();
    test_reset();
    test_fill();
    test_hold();
    test_impulse();
    test_clear_collide();
    test_async_reset();
`ifdef SYM_PREADD_EN
    test_preadd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
